// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one fixed-latency multiplier
//
// Purpose: two requesters take turns on one WIDTH x WIDTH multiplier. In IDLE the
// winner's operands are registered onto the multiplier inputs. The block then
// pulses the winner's ack together with mul_start, counts out LATENCY cycles,
// captures the product and pulses the winner's response valid.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_req0/i_a0/i_b0      requester 0 request and operands (held until o_ack0)
//   o_ack0                one-cycle pulse: requester 0 operands captured
//   i_req1/i_a1/i_b1      requester 1 request and operands (held until o_ack1)
//   o_ack1                one-cycle pulse: requester 1 operands captured
//   o_mul_a, o_mul_b      registered multiplier operands
//   o_mul_start           one-cycle multiplier start pulse
//   i_mul_result          multiplier product, valid LATENCY cycles after start
//   o_rsp_valid0/1        one-cycle pulse: o_rsp_data belongs to requester 0/1
//   o_rsp_data            last product, held until the next response
//   o_busy                high in every state except IDLE
module mul_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0,
  input  logic [WIDTH-1:0]   i_a0,
  input  logic [WIDTH-1:0]   i_b0,
  output logic               o_ack0,
  input  logic               i_req1,
  input  logic [WIDTH-1:0]   i_a1,
  input  logic [WIDTH-1:0]   i_b1,
  output logic               o_ack1,
  output logic [WIDTH-1:0]   o_mul_a,
  output logic [WIDTH-1:0]   o_mul_b,
  output logic               o_mul_start,
  input  logic [2*WIDTH-1:0] i_mul_result,
  output logic               o_rsp_valid0,
  output logic               o_rsp_valid1,
  output logic [2*WIDTH-1:0] o_rsp_data,
  output logic               o_busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               r_state, w_state;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic                 r_ptr, w_ptr;     // requester that wins a tie
  logic                 r_win, w_win;     // requester owning the current operation
  logic [WIDTH-1:0]     r_mul_a, w_mul_a;
  logic [WIDTH-1:0]     r_mul_b, w_mul_b;
  logic                 r_ack0, w_ack0;
  logic                 r_ack1, w_ack1;
  logic                 r_start, w_start;
  logic                 r_rv0, w_rv0;
  logic                 r_rv1, w_rv1;
  logic [2*WIDTH-1:0]   r_rsp, w_rsp;
  logic                 r_busy, w_busy;
  logic                 w_pick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_start <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_rsp   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
      r_win   <= w_win;
      r_mul_a <= w_mul_a;
      r_mul_b <= w_mul_b;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_start <= w_start;
      r_rv0   <= w_rv0;
      r_rv1   <= w_rv1;
      r_rsp   <= w_rsp;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_ptr   = r_ptr;
    w_win   = r_win;
    w_mul_a = r_mul_a;
    w_mul_b = r_mul_b;
    w_ack0  = 1'b0;
    w_ack1  = 1'b0;
    w_start = 1'b0;
    w_rv0   = 1'b0;
    w_rv1   = 1'b0;
    w_rsp   = r_rsp;
    // Pointed requester wins if it asks, otherwise the other one.
    w_pick  = r_ptr ? i_req1 : ~i_req0;

    case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          w_win   = w_pick;
          w_mul_a = w_pick ? i_a1 : i_a0;
          w_mul_b = w_pick ? i_b1 : i_b0;
          // ack and start are registered here so they appear during ISSUE.
          w_ack0  = ~w_pick;
          w_ack1  = w_pick;
          w_start = 1'b1;
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt   = CNT_LOAD;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        // Counter hits zero in the cycle the product becomes valid.
        if (r_cnt == '0) begin
          w_rsp   = i_mul_result;
          w_rv0   = ~r_win;
          w_rv1   = r_win;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_ptr   = ~r_win;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE);
  end

  assign o_ack0       = r_ack0;
  assign o_ack1       = r_ack1;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_mul_start  = r_start;
  assign o_rsp_valid0 = r_rv0;
  assign o_rsp_valid1 = r_rv1;
  assign o_rsp_data   = r_rsp;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;

  localparam int W   = 8;
  localparam int LAT = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           ack0, ack1, mul_start, rv0, rv1, busy;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_result, rsp_data;

  mul_share_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_a0(a0), .i_b0(b0), .o_ack0(ack0),
    .i_req1(req1), .i_a1(a1), .i_b1(b1), .o_ack1(ack1),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_start(mul_start),
    .i_mul_result(mul_result),
    .o_rsp_valid0(rv0), .o_rsp_valid1(rv1), .o_rsp_data(rsp_data),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product presented only in the cycle LAT after start.
  logic [2*W:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= {mul_start, 16'(16'(mul_a) * 16'(mul_b))};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_result = pipe[LAT-1][2*W] ? pipe[LAT-1][2*W-1:0] : 16'hDEAD;

  typedef struct {
    bit          id;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;
  int last_cyc [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit id, input logic [15:0] d);
    exp_t x;
    x.id = id;
    x.data = d;
    sb.push_back(x);
  endtask

  // Monitor: every response pulse pops one expected entry.
  always @(negedge clk) begin
    if (rv0 || rv1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'({rv1, rv0}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'({rv1, rv0}), e.id ? 32'd2 : 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        last_cyc[rv1 ? 1 : 0] = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      if (sb.size() == 0 && !busy && !req0 && !req1) done = 1'b1;
    end
    check({name, "_drain"}, 32'(done), 32'd1);
  endtask

  initial begin
    int c0;
    int n0;
    int n1;
    bit done;

    // Reset state
    do_reset();
    check("reset_outputs",
          32'({ack0, ack1, mul_start, rv0, rv1, busy}), 32'd0);
    check("reset_data", 32'({mul_a, mul_b, rsp_data}), 32'd0);

    // 1. Single request: 20*23 = 0x01CC
    req0 = 1'b1; a0 = 8'd20; b0 = 8'd23;
    push(1'b0, 16'h01CC);
    c0 = cyc;
    step();
    check("t1_ack0_start", 32'({ack0, ack1, mul_start, busy}), 32'b1011);
    check("t1_mul_ops", 32'({mul_a, mul_b}), 32'({8'd20, 8'd23}));
    req0 = 1'b0;
    while (cyc < c0 + 11) begin
      check("t1_no_early_rsp", 32'({rv0, rv1}), 32'd0);
      step();
    end
    check("t1_rsp_cycle", 32'({rv0, rv1}), 32'b10);
    step();
    check("t1_busy_low", 32'(busy), 32'd0);
    drain("t1", 20);

    // 2. Simultaneous requests after reset: requester 0 first, then 1 twelve cycles later
    do_reset();
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd4;
    req1 = 1'b1; a1 = 8'd5; b1 = 8'd6;
    push(1'b0, 16'h000C);
    push(1'b1, 16'h001E);
    drain("t2", 60);
    check("t2_gap", 32'(last_cyc[1] - last_cyc[0]), 32'd12);

    // 3. Fairness: req0 held for four operations, req1 raised on each ack0
    do_reset();
    req0 = 1'b1; a0 = 8'd7; b0 = 8'd9;
    a1 = 8'd11; b1 = 8'd13;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 16'd63);
      push(1'b1, 16'd143);
    end
    n0 = 0; n1 = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (ack0) begin
        n0++;
        if (n0 == 4) req0 = 1'b0;
        req1 = 1'b1;
      end
      if (ack1) begin
        n1++;
        req1 = 1'b0;
      end
      if (n0 == 4 && sb.size() == 0 && !busy && !req1) done = 1'b1;
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_ack_counts", 32'({8'(n0), 8'(n1)}), 32'h0404);

    // 4. Boundary operands
    do_reset();
    req1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
    push(1'b1, 16'hFE01);
    drain("t4_ff", 30);
    req0 = 1'b1; a0 = 8'h00; b0 = 8'hAB;
    push(1'b0, 16'h0000);
    drain("t4_zero", 30);

    // 5. Reset during WAIT aborts; a later request is served normally
    do_reset();
    req0 = 1'b1; a0 = 8'd20; b0 = 8'd23;
    step();
    req0 = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    check("t5_reset_ctrl",
          32'({ack0, ack1, mul_start, rv0, rv1, busy}), 32'd0);
    check("t5_reset_data", 32'({mul_a, mul_b, rsp_data}), 32'd0);
    rst = 1'b0;
    repeat (15) step();
    req1 = 1'b1; a1 = 8'd9; b1 = 8'd10;
    push(1'b1, 16'd90);
    drain("t5_after", 30);

    // 6. Operand change while busy is ignored
    do_reset();
    req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
    push(1'b0, 16'h03A8);
    step();
    step();
    req0 = 1'b0;
    step();
    a0 = 8'hFF; b0 = 8'hFF;
    repeat (3) step();
    check("t6_ops_stable", 32'({mul_a, mul_b}), 32'h1234);
    drain("t6", 30);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
